// File: rtl/imm_decode_stage_pkg.sv
// Shared definitions for the immediate-decode stage.
//   IMM_* : format-select encodings for in_imm_src (101..111 are reserved)
//   buf_state_e : occupancy of the two-entry output/skid buffer
//   dec_entry_t : one decoded entry; imm is held at the widest legal XLEN
//                 and truncated to the instance XLEN at the output
package imm_decode_stage_pkg;

  localparam int IMM_MAX_W = 64;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } buf_state_e;

  typedef struct packed {
    logic [4:0]           a1;
    logic [4:0]           a2;
    logic [4:0]           a3;
    logic [IMM_MAX_W-1:0] imm;
    logic                 illegal;
  } dec_entry_t;

endpackage

// File: rtl/imm_decode_stage_imm_gen.sv
// Combinational immediate generator.
//   inst    in  32    raw instruction word
//   imm_src in  3     format select (I/S/B/U/J, others reserved)
//   imm     out XLEN  immediate sign-extended from inst[31]
//   illegal out 1     imm_src was a reserved encoding (imm forced to 0)
module imm_gen
  import imm_decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  logic [2:0]      imm_src,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  // Every format is built at 64 bits and then truncated, so the U-type
  // upper sign bits simply disappear when XLEN is 32.
  logic signed [63:0] imm_full;
  logic               unused_bits;

  always_comb begin
    imm_full = '0;
    illegal  = 1'b0;
    case (imm_src)
      IMM_I:   imm_full = {{52{inst[31]}}, inst[31:20]};
      IMM_S:   imm_full = {{52{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm_full = {{52{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm_full = {{32{inst[31]}}, inst[31:12], 12'b0};
      IMM_J:   imm_full = {{44{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      default: illegal  = 1'b1;
    endcase
  end

  assign imm         = imm_full[XLEN-1:0];
  assign unused_bits = ^{imm_full, inst[6:0]};

endmodule

// File: rtl/imm_decode_stage.sv
// Registered field-extraction / immediate-generation stage with a
// two-entry skid buffer on a valid/ready handshake.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake (in_ready = skid entry empty)
//   in_inst, in_imm_src   instruction word and immediate format select
//   flush                 synchronous discard of all buffered entries
//   out_valid/out_ready   downstream handshake
//   out_a1/a2/a3          rs1/rs2/rd fields of the buffered instruction
//   out_imm, out_illegal  extended immediate, reserved-select flag
module imm_decode_stage
  import imm_decode_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [2:0]        in_imm_src,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] out_a1,
  output logic [REG_AW-1:0] out_a2,
  output logic [REG_AW-1:0] out_a3,
  output logic [XLEN-1:0]   out_imm,
  output logic              out_illegal
);

  buf_state_e      state, state_nxt;
  dec_entry_t      dec_p0, out_p1, skid_p1;
  logic [XLEN-1:0] gen_imm;
  logic            gen_illegal;
  logic            accept;
  logic            load_out, load_skid, move_skid;
  logic            unused_imm;

  // Stage 0: combinational decode of the incoming instruction
  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst    (in_inst),
    .imm_src (in_imm_src),
    .imm     (gen_imm),
    .illegal (gen_illegal)
  );

  always_comb begin
    dec_p0.a1      = in_inst[19:15];
    dec_p0.a2      = in_inst[24:20];
    dec_p0.a3      = in_inst[11:7];
    dec_p0.imm     = IMM_MAX_W'(gen_imm);
    dec_p0.illegal = gen_illegal;
  end

  // Both handshake outputs decode the state register only, so neither
  // in_ready nor out_* has a combinational path from the inputs.
  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            load_out  = 1'b1;
            state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && out_ready) begin
            load_out = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_nxt = ST_FULL;
          end else if (out_ready) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            move_skid = 1'b1;
            state_nxt = ST_ONE;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  // Stage 1: output register and skid register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p1  <= '0;
      skid_p1 <= '0;
    end else begin
      if (load_out)       out_p1 <= dec_p0;
      else if (move_skid) out_p1 <= skid_p1;
      if (load_skid)      skid_p1 <= dec_p0;
    end
  end

  assign out_a1      = REG_AW'(out_p1.a1);
  assign out_a2      = REG_AW'(out_p1.a2);
  assign out_a3      = REG_AW'(out_p1.a3);
  assign out_imm     = out_p1.imm[XLEN-1:0];
  assign out_illegal = out_p1.illegal;
  assign unused_imm  = ^out_p1.imm;

endmodule

// File: tb/tb_imm_decode_stage.sv
module tb_imm_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [2:0]  in_imm_src;
  logic        flush;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, ill_a;
  logic [4:0]  a1_a, a2_a, a3_a;
  logic [31:0] imm_a;
  logic        in_ready_b, out_valid_b, ill_b;
  logic [4:0]  a1_b, a2_b, a3_b;
  logic [63:0] imm_b;

  int total;
  int passed;

  imm_decode_stage #(.XLEN(32), .REG_AW(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_inst(in_inst), .in_imm_src(in_imm_src), .flush(flush),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_a1(a1_a), .out_a2(a2_a), .out_a3(a3_a),
    .out_imm(imm_a), .out_illegal(ill_a)
  );

  imm_decode_stage #(.XLEN(64), .REG_AW(5)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_inst(in_inst), .in_imm_src(in_imm_src), .flush(flush),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_a1(a1_b), .out_a2(a2_b), .out_a3(a3_b),
    .out_imm(imm_b), .out_illegal(ill_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  src;
    logic [63:0] imm;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  a3;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  a3;
    logic [63:0] imm;
    logic        ill;
  } entry_t;

  vec_t   vecs[8];
  entry_t q[$];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Immediate value from the ISA's field layout, using shifts/masks and
  // two's-complement wrap on the natural field width.
  function automatic logic [63:0] ref_imm(logic [31:0] inst, logic [2:0] src);
    longint unsigned w;
    longint          v;
    w = 64'(inst);
    v = 0;
    case (src)
      3'd0: begin
        v = longint'((w >> 20) & 'hFFF);
        if (v >= 2048) v -= 4096;
      end
      3'd1: begin
        v = longint'((((w >> 25) & 127) << 5) | ((w >> 7) & 31));
        if (v >= 2048) v -= 4096;
      end
      3'd2: begin
        v = longint'((((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) |
                     (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1));
        if (v >= 4096) v -= 8192;
      end
      3'd3: begin
        v = longint'(w & 64'hFFFF_F000);
        if (v >= 64'sd2147483648) v -= 64'sd4294967296;
      end
      3'd4: begin
        v = longint'((((w >> 31) & 1) << 20) | (((w >> 12) & 255) << 12) |
                     (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1));
        if (v >= 1048576) v -= 2097152;
      end
      default: v = 0;
    endcase
    return 64'(v);
  endfunction

  function automatic entry_t mk_entry(logic [31:0] inst, logic [2:0] src);
    entry_t e;
    e.a1  = inst[19:15];
    e.a2  = inst[24:20];
    e.a3  = inst[11:7];
    e.imm = ref_imm(inst, src);
    e.ill = (src > 3'd4);
    return e;
  endfunction

  task automatic chk_out(string tag, logic [4:0] a1, logic [4:0] a2, logic [4:0] a3,
                         logic [63:0] imm, logic ill);
    check({tag, ".vld32"}, out_valid_a, 1);
    check({tag, ".vld64"}, out_valid_b, 1);
    check({tag, ".a1"}, a1_a, a1);
    check({tag, ".a2"}, a2_a, a2);
    check({tag, ".a3"}, a3_a, a3);
    check({tag, ".a3_64"}, a3_b, a3);
    check({tag, ".imm32"}, imm_a, imm[31:0]);
    check({tag, ".imm64"}, imm_b, imm);
    check({tag, ".ill32"}, ill_a, ill);
    check({tag, ".ill64"}, ill_b, ill);
  endtask

  task automatic chk_vec(string tag, int i);
    chk_out(tag, vecs[i].a1, vecs[i].a2, vecs[i].a3, vecs[i].imm, vecs[i].ill);
  endtask

  task automatic chk_idle(string tag, logic exp_rdy);
    check({tag, ".vld32"}, out_valid_a, 0);
    check({tag, ".vld64"}, out_valid_b, 0);
    check({tag, ".rdy32"}, in_ready_a, 64'(exp_rdy));
    check({tag, ".rdy64"}, in_ready_b, 64'(exp_rdy));
  endtask

  task automatic drive(logic v, int i);
    in_valid   = v;
    in_inst    = vecs[i].inst;
    in_imm_src = vecs[i].src;
  endtask

  task automatic chk_reset_vals(string tag);
    chk_idle(tag, 1'b1);
    check({tag, ".imm32"}, imm_a, 0);
    check({tag, ".imm64"}, imm_b, 0);
    check({tag, ".a1"}, a1_a, 0);
    check({tag, ".a2"}, a2_a, 0);
    check({tag, ".a3"}, a3_a, 0);
    check({tag, ".ill"}, ill_a, 0);
  endtask

  initial begin
    total      = 0;
    passed     = 0;
    rst_n      = 1'b1;
    in_valid   = 1'b0;
    in_inst    = '0;
    in_imm_src = '0;
    flush      = 1'b0;
    out_ready  = 1'b0;

    vecs[0] = '{32'hFFF10093, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2,  5'd31, 5'd1,  1'b0};
    vecs[1] = '{32'h00112623, 3'b001, 64'h0000_0000_0000_000C, 5'd2,  5'd1,  5'd12, 1'b0};
    vecs[2] = '{32'hFE000EE3, 3'b010, 64'hFFFF_FFFF_FFFF_FFFC, 5'd0,  5'd0,  5'd29, 1'b0};
    vecs[3] = '{32'h123452B7, 3'b011, 64'h0000_0000_1234_5000, 5'd8,  5'd3,  5'd5,  1'b0};
    vecs[4] = '{32'h123452B7, 3'b111, 64'h0000_0000_0000_0000, 5'd8,  5'd3,  5'd5,  1'b1};
    vecs[5] = '{32'h800002B7, 3'b011, 64'hFFFF_FFFF_8000_0000, 5'd0,  5'd0,  5'd5,  1'b0};
    vecs[6] = '{32'hFF9FF0EF, 3'b100, 64'hFFFF_FFFF_FFFF_FFF8, 5'd31, 5'd25, 5'd1,  1'b0};
    vecs[7] = '{32'hFF9FF0EF, 3'b101, 64'h0000_0000_0000_0000, 5'd31, 5'd25, 5'd1,  1'b1};

    #1 rst_n = 1'b0;
    #1 chk_reset_vals("reset");
    step();
    step();
    @(negedge clk) rst_n = 1'b1;
    step();
    chk_idle("post_reset", 1'b1);

    // Single entries: visible one edge after accept, gone the edge after.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i);
      out_ready = 1'b1;
      step();
      chk_vec($sformatf("vec%0d", i), i);
      in_valid = 1'b0;
      step();
      chk_idle($sformatf("vec%0d_drain", i), 1'b1);
    end

    // Backpressure: three back-to-back inputs with the consumer stalled.
    out_ready = 1'b0;
    drive(1'b1, 0);
    step();
    chk_vec("bp_first", 0);
    check("bp_rdy_after1", in_ready_a, 1);
    drive(1'b1, 1);
    step();
    check("bp_rdy_after2", in_ready_a, 0);
    check("bp_rdy_after2_64", in_ready_b, 0);
    chk_vec("bp_stall_a", 0);
    drive(1'b1, 2);
    step();
    check("bp_held_off", in_ready_a, 0);
    chk_vec("bp_stall_b", 0);
    step();
    chk_vec("bp_stall_c", 0);
    out_ready = 1'b1;
    step();
    chk_vec("bp_order2", 1);
    check("bp_rdy_reopen", in_ready_a, 1);
    step();
    chk_vec("bp_order3", 2);
    in_valid = 1'b0;
    step();
    chk_idle("bp_drained", 1'b1);

    // Flush while full with a simultaneous input that must be discarded.
    out_ready = 1'b0;
    drive(1'b1, 0);
    step();
    drive(1'b1, 1);
    step();
    check("fl_full", in_ready_a, 0);
    drive(1'b1, 3);
    flush = 1'b1;
    step();
    chk_idle("fl_after", 1'b1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk_idle("fl_nothing1", 1'b1);
    step();
    chk_idle("fl_nothing2", 1'b1);

    // Asynchronous reset between clock edges while holding an entry.
    out_ready = 1'b0;
    drive(1'b1, 5);
    step();
    chk_vec("ar_loaded", 5);
    drive(1'b1, 6);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("ar_immediate");
    in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    step();
    chk_idle("ar_after", 1'b1);

    // Randomized traffic against a queue model of the two-entry buffer.
    q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic exp_rdy;
      logic v, r, f;
      logic [31:0] inst;
      logic [2:0]  src;
      exp_rdy = (q.size() < 2);
      check("rnd.vld32", out_valid_a, 64'(q.size() > 0));
      check("rnd.vld64", out_valid_b, 64'(q.size() > 0));
      check("rnd.rdy32", in_ready_a, 64'(exp_rdy));
      check("rnd.rdy64", in_ready_b, 64'(exp_rdy));
      if (q.size() > 0) begin
        check("rnd.a1", a1_a, q[0].a1);
        check("rnd.a2", a2_b, q[0].a2);
        check("rnd.a3", a3_a, q[0].a3);
        check("rnd.imm32", imm_a, q[0].imm[31:0]);
        check("rnd.imm64", imm_b, q[0].imm);
        check("rnd.ill", ill_a, q[0].ill);
      end
      v    = ($urandom_range(0, 3) != 0);
      r    = ($urandom_range(0, 2) != 0);
      f    = ($urandom_range(0, 31) == 0);
      inst = $urandom;
      src  = 3'($urandom_range(0, 7));
      in_valid   = v;
      out_ready  = r;
      flush      = f;
      in_inst    = inst;
      in_imm_src = src;
      @(posedge clk);
      if (f) begin
        q.delete();
      end else begin
        if (r && q.size() > 0) void'(q.pop_front());
        if (v && exp_rdy) q.push_back(mk_entry(inst, src));
      end
      #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
